hazard_detection_unit_mips: RTL

Stall/flush controller for the five-stage MIPS pipeline; the counterpart of the forwarding path. Forwarding resolves hazards by bypassing data. This block resolves the cases bypassing cannot: load-use, taken-branch wrong-path and multi-cycle data-memory waits. It does so by freezing pipeline registers and injecting bubbles. It sits beside the Decode stage, observes Decode/Execute/MemoryAccess fields and drives the enables of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/hazard_detection_unit_mips_if.sv | 43 ++++
 rtl/hazard_detection_unit_mips.sv | 79 +++++++
 2 files changed

// File: rtl/hazard_detection_unit_mips_if.sv
// hazard_detection_unit_mips_if: pipeline-field / control bundle between the MIPS datapath and the hazard unit.
//   Observed fields (master drives): Decode rs/rt/useReadB/store, Execute load/dest/branchTaken,
//   MemoryAccess request/ready.
//   Control results (slave drives): four stage stalls, IF/ID flush, ID/EX bubble,
//   FSM state, sticky memory timeout, stall-cycle counter.
interface hazard_detection_unit_mips_if;
  logic [4:0]  addressReadARegisterFile_Decode;
  logic [4:0]  addressReadBRegisterFile_Decode;
  logic        useReadB_Decode;
  logic        enableWriteDataMemory_Decode;
  logic        enableReadDataMemory_Execute;
  logic [4:0]  addressWriteRegisterFile_Execute;
  logic        branchTaken_Execute;
  logic        memoryRequest_MemoryAccess;
  logic        memoryReady_MemoryAccess;
  logic        stallFetch_HazardUnit;
  logic        stallDecode_HazardUnit;
  logic        stallExecute_HazardUnit;
  logic        stallMemory_HazardUnit;
  logic        flushDecode_HazardUnit;
  logic        bubbleExecute_HazardUnit;
  logic [1:0]  state_HazardUnit;
  logic        memoryTimeout_HazardUnit;
  logic [15:0] stallCycles_HazardUnit;
  modport master (
    output addressReadARegisterFile_Decode, addressReadBRegisterFile_Decode, useReadB_Decode,
           enableWriteDataMemory_Decode, enableReadDataMemory_Execute,
           addressWriteRegisterFile_Execute, branchTaken_Execute,
           memoryRequest_MemoryAccess, memoryReady_MemoryAccess,
    input  stallFetch_HazardUnit, stallDecode_HazardUnit, stallExecute_HazardUnit,
           stallMemory_HazardUnit, flushDecode_HazardUnit, bubbleExecute_HazardUnit,
           state_HazardUnit, memoryTimeout_HazardUnit, stallCycles_HazardUnit
  );
  modport slave (
    input  addressReadARegisterFile_Decode, addressReadBRegisterFile_Decode, useReadB_Decode,
           enableWriteDataMemory_Decode, enableReadDataMemory_Execute,
           addressWriteRegisterFile_Execute, branchTaken_Execute,
           memoryRequest_MemoryAccess, memoryReady_MemoryAccess,
    output stallFetch_HazardUnit, stallDecode_HazardUnit, stallExecute_HazardUnit,
           stallMemory_HazardUnit, flushDecode_HazardUnit, bubbleExecute_HazardUnit,
           state_HazardUnit, memoryTimeout_HazardUnit, stallCycles_HazardUnit
  );
endinterface

// File: rtl/hazard_detection_unit_mips.sv
// hazard_detection_unit_mips: stall/flush controller for the five-stage MIPS pipeline.
//   clk, reset_n (async active-low) plain ports; everything else via hazard_detection_unit_mips_if.slave.
//   Stall/flush/bubble outputs are combinational from current fields (priority: memory wait >
//   taken branch > load-use) and forced low during reset. state, wait counter, sticky timeout
//   and stall-cycle counter are registered.
//   Optional macro HAZARD_STALL_COUNTER_EN enables the 16-bit saturating stallCycles counter;
//   without it stallCycles_HazardUnit reads 0.
module hazard_detection_unit_mips #(
  parameter int unsigned MEM_TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset_n,
  hazard_detection_unit_mips_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT_CYCLES);
  state_t state, state_next;
  logic [7:0] wait_count, wait_next;
  logic timeout;
  logic mw, lu, br;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, bubble_e;
  assign mw = hz.memoryRequest_MemoryAccess && !hz.memoryReady_MemoryAccess;
  assign br = hz.branchTaken_Execute;
  // A store's data register (rt) is served by memory-to-memory forwarding, so only its base counts.
  assign lu = hz.enableReadDataMemory_Execute && hz.addressWriteRegisterFile_Execute != 5'd0 &&
              (hz.addressReadARegisterFile_Decode == hz.addressWriteRegisterFile_Execute ||
               (hz.useReadB_Decode && !hz.enableWriteDataMemory_Decode &&
                hz.addressReadBRegisterFile_Decode == hz.addressWriteRegisterFile_Execute));
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    bubble_e = 1'b0;
    state_next = RUN;
    if (mw) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      state_next = MEM_WAIT;
    end else if (br) begin
      flush_d = 1'b1;
      bubble_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      bubble_e = 1'b1;
      state_next = LOAD_STALL;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_next;
  assign wait_next = !mw ? 8'd0 : wait_count == 8'hFF ? wait_count : wait_count + 8'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wait_count <= 8'd0;
      timeout <= 1'b0;
    end else begin
      wait_count <= wait_next;
      timeout <= timeout || (mw && wait_next >= TIMEOUT);
    end
  assign hz.stallFetch_HazardUnit    = reset_n && stall_f;
  assign hz.stallDecode_HazardUnit   = reset_n && stall_d;
  assign hz.stallExecute_HazardUnit  = reset_n && stall_e;
  assign hz.stallMemory_HazardUnit   = reset_n && stall_m;
  assign hz.flushDecode_HazardUnit   = reset_n && flush_d;
  assign hz.bubbleExecute_HazardUnit = reset_n && bubble_e;
  assign hz.state_HazardUnit         = state;
  assign hz.memoryTimeout_HazardUnit = timeout;
`ifdef HAZARD_STALL_COUNTER_EN
  logic [15:0] stall_cycles;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_cycles <= 16'd0;
    else if (stall_f && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  assign hz.stallCycles_HazardUnit = stall_cycles;
`else
  assign hz.stallCycles_HazardUnit = 16'h0000;
`endif
endmodule
